// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: mode encodings and tree-depth helper shared by scan_mux_tree
package scan_mux_pkg;
  typedef enum logic {MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1} mode_e;
  function automatic int levels_f(input int n_ch);
    return ($clog2(n_ch) + 1) / 2;
  endfunction
endpackage

// File: rtl/scan_mux_tree_mux4_stage.sv
// mux4_stage: registered 4:1 tree node; i_in0..i_in3 data, i_sel picks one, i_valid/i_psel ride alongside to o_valid/o_psel
module mux4_stage #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_in0,
  input  logic [DATA_W-1:0] i_in1,
  input  logic [DATA_W-1:0] i_in2,
  input  logic [DATA_W-1:0] i_in3,
  input  logic [1:0]        i_sel,
  input  logic              i_valid,
  input  logic [SEL_W-1:0]  i_psel,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [SEL_W-1:0]  o_psel
);
  logic [DATA_W-1:0] w_mux;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic [SEL_W-1:0]  r_psel;
  assign w_mux = i_sel[1] ? (i_sel[0] ? i_in3 : i_in2) : (i_sel[0] ? i_in1 : i_in0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_psel  <= '0;
    end else begin
      r_data  <= w_mux;
      r_valid <= i_valid;
      r_psel  <= i_psel;
    end
  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_psel  = r_psel;
endmodule

// File: rtl/scan_mux_tree.sv
// scan_mux_tree: pipelined N_CH:1 mux tree of registered 4:1 stages with manual select or auto-scan
//   in_data/in_valid: channels (ch c at [c*DATA_W +: DATA_W]) and qualifier
//   sel/mode/dwell:   manual select, 0=manual 1=scan, scan cycles per channel minus 1
//   out_data/out_sel/out_valid: selected channel, its index and valid, LEVELS cycles later
//   out_par: even parity of out_data, present only when SCAN_MUX_PARITY_EN is defined
module scan_mux_tree
  import scan_mux_pkg::*;
#(
  parameter int N_CH    = 8,
  parameter int DATA_W  = 8,
  parameter int DWELL_W = 8,
  localparam int SEL_W  = $clog2(N_CH),
  localparam int LEVELS = levels_f(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic                   in_valid,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   mode,
  input  logic [DWELL_W-1:0]     dwell,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_sel,
  output logic                   out_valid
`ifdef SCAN_MUX_PARITY_EN
  , output logic                 out_par
`endif
);
  logic [SEL_W-1:0]   r_scan_ch;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic [SEL_W-1:0]   w_eff_sel;
  // Counter is parked at 0 in manual mode so a switch into scan always starts at channel 0;
  // >= lets a lowered dwell take effect on the next cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_scan_ch   <= '0;
      r_dwell_cnt <= '0;
    end else if (mode != MODE_SCAN) begin
      r_scan_ch   <= '0;
      r_dwell_cnt <= '0;
    end else if (r_dwell_cnt >= dwell) begin
      r_scan_ch   <= r_scan_ch + SEL_W'(1);
      r_dwell_cnt <= '0;
    end else begin
      r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
    end
  assign w_eff_sel = (mode == MODE_SCAN) ? r_scan_ch : sel;
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int INS   = N_CH >> (2 * k);
    localparam int NODES = (INS + 3) / 4;
    logic [NODES*4*DATA_W-1:0] w_in;
    logic                      w_vin;
    logic [SEL_W-1:0]          w_sin;
    logic [1:0]                w_s2;
    logic [NODES*DATA_W-1:0]   w_out;
    logic [NODES-1:0]          w_vout;
    logic [NODES*SEL_W-1:0]    w_sout;
    if (k == 0) begin : g_src
      assign w_in  = (NODES*4*DATA_W)'(in_data);
      assign w_vin = in_valid;
      assign w_sin = w_eff_sel;
    end else begin : g_src
      localparam int PN = ((N_CH >> (2 * (k - 1))) + 3) / 4;
      // Every node of a level carries the same valid/select copy, so OR-merging them is exact.
      assign w_in  = (NODES*4*DATA_W)'(g_lvl[k-1].w_out);
      assign w_vin = |g_lvl[k-1].w_vout;
      always_comb begin
        w_sin = '0;
        for (int i = 0; i < PN; i++) w_sin = w_sin | g_lvl[k-1].w_sout[i*SEL_W +: SEL_W];
      end
    end
    // An odd select width leaves a 2-input top level driven by a single select bit.
    if (2 * k + 1 < SEL_W) begin : g_s2
      assign w_s2 = w_sin[2*k+1:2*k];
    end else begin : g_s2
      assign w_s2 = {1'b0, w_sin[2*k]};
    end
    for (genvar n = 0; n < NODES; n++) begin : g_node
      mux4_stage #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_mux (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_in0   (w_in[(4*n+0)*DATA_W +: DATA_W]),
        .i_in1   (w_in[(4*n+1)*DATA_W +: DATA_W]),
        .i_in2   (w_in[(4*n+2)*DATA_W +: DATA_W]),
        .i_in3   (w_in[(4*n+3)*DATA_W +: DATA_W]),
        .i_sel   (w_s2),
        .i_valid (w_vin),
        .i_psel  (w_sin),
        .o_data  (w_out[n*DATA_W +: DATA_W]),
        .o_valid (w_vout[n]),
        .o_psel  (w_sout[n*SEL_W +: SEL_W])
      );
    end
  end
  assign out_data  = g_lvl[LEVELS-1].w_out;
  assign out_sel   = g_lvl[LEVELS-1].w_sout;
  assign out_valid = g_lvl[LEVELS-1].w_vout[0];
`ifdef SCAN_MUX_PARITY_EN
  logic [DATA_W-1:0] w_par_in;
  logic              r_par;
  // Parity taken from the last stage's mux input so it lands in the same cycle as out_data.
  assign w_par_in = g_lvl[LEVELS-1].w_in[g_lvl[LEVELS-1].w_s2*DATA_W +: DATA_W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_par <= 1'b0;
    else r_par <= ^w_par_in;
  assign out_par = r_par;
`endif
endmodule

// File: tb/tb_scan_mux_tree.sv
// tb_scan_mux_tree: directed checks of the 8-channel and 32-channel scan mux trees
module tb_scan_mux_tree;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [63:0]  in_data;
  logic         in_valid;
  logic [2:0]   sel;
  logic         mode;
  logic [7:0]   dwell;
  logic [7:0]   out_data;
  logic [2:0]   out_sel;
  logic         out_valid;
  logic [255:0] in_data32;
  logic         in_valid32;
  logic [4:0]   sel32;
  logic         mode32 = 1'b0;
  logic [7:0]   dwell32 = 8'd0;
  logic [7:0]   out_data32;
  logic [4:0]   out_sel32;
  logic         out_valid32;
`ifdef SCAN_MUX_PARITY_EN
  logic         out_par;
  logic         out_par32;
`endif
  int n_cmp = 0;
  int n_err = 0;
  scan_mux_tree #(.N_CH(8), .DATA_W(8), .DWELL_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .sel(sel),
    .mode(mode), .dwell(dwell), .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid)
`ifdef SCAN_MUX_PARITY_EN
    , .out_par(out_par)
`endif
  );
  scan_mux_tree #(.N_CH(32), .DATA_W(8), .DWELL_W(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data32), .in_valid(in_valid32), .sel(sel32),
    .mode(mode32), .dwell(dwell32), .out_data(out_data32), .out_sel(out_sel32), .out_valid(out_valid32)
`ifdef SCAN_MUX_PARITY_EN
    , .out_par(out_par32)
`endif
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; sel = 3'd3; mode = 1'b0; dwell = 8'd0;
    for (int c = 0; c < 8; c++) in_data[c*8 +: 8] = 8'(8'h10 + c);
    for (int c = 0; c < 32; c++) in_data32[c*8 +: 8] = 8'(c);
    in_data32[31*8 +: 8] = 8'hA5; in_valid32 = 1'b1; sel32 = 5'd0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", out_data); end
      n_cmp++; if (out_valid32 !== 1'b0) begin n_err++; $display("FAIL reset_valid32: got %b want 0", out_valid32); end
    end
    rst_n = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset1_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL post_reset1_data: got %h want 00", out_data); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL post_reset2_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 8'h13) begin n_err++; $display("FAIL post_reset2_data: got %h want 13", out_data); end
    n_cmp++; if (out_sel !== 3'd3) begin n_err++; $display("FAIL post_reset2_sel: got %0d want 3", out_sel); end
  endtask
  task automatic test_manual();
    logic [2:0] s [4];
    logic [7:0] d [4];
    logic       p [4];
    s = '{3'd5, 3'd2, 3'd7, 3'd0};
    d = '{8'h15, 8'h12, 8'h17, 8'h10};
    p = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sel = s[i];
      step();
      if (i > 0) begin
        n_cmp++; if (out_data !== d[i-1]) begin n_err++; $display("FAIL manual_data[%0d]: got %h want %h", i-1, out_data, d[i-1]); end
        n_cmp++; if (out_sel !== s[i-1]) begin n_err++; $display("FAIL manual_sel[%0d]: got %0d want %0d", i-1, out_sel, s[i-1]); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL manual_valid[%0d]: got %b want 1", i-1, out_valid); end
`ifdef SCAN_MUX_PARITY_EN
        n_cmp++; if (out_par !== p[i-1]) begin n_err++; $display("FAIL manual_par[%0d]: got %b want %b", i-1, out_par, p[i-1]); end
`endif
      end
    end
  endtask
  task automatic test_scan_dwell0();
    logic [2:0] ch;
    mode = 1'b0; step();
    mode = 1'b1; dwell = 8'd0; step();
    for (int j = 0; j < 9; j++) begin
      step();
      ch = 3'(j % 8);
      n_cmp++; if (out_sel !== ch) begin n_err++; $display("FAIL scan0_sel[%0d]: got %0d want %0d", j, out_sel, ch); end
      n_cmp++; if (out_data !== 8'(8'h10 + ch)) begin n_err++; $display("FAIL scan0_data[%0d]: got %h want %h", j, out_data, 8'(8'h10 + ch)); end
    end
  endtask
  task automatic test_scan_dwell2();
    logic [2:0] ch;
    mode = 1'b0; step();
    mode = 1'b1; dwell = 8'd2; step();
    for (int j = 0; j < 29; j++) begin
      if (j == 26) begin mode = 1'b0; sel = 3'd6; end
      step();
      ch = (j >= 27) ? 3'd6 : 3'((j / 3) % 8);
      n_cmp++; if (out_sel !== ch) begin n_err++; $display("FAIL scan2_sel[%0d]: got %0d want %0d", j, out_sel, ch); end
      n_cmp++; if (out_data !== 8'(8'h10 + ch)) begin n_err++; $display("FAIL scan2_data[%0d]: got %h want %h", j, out_data, 8'(8'h10 + ch)); end
    end
  endtask
  task automatic test_async_reset();
    mode = 1'b0; step();
    mode = 1'b1; dwell = 8'd0; step(); step(); step();
    n_cmp++; if (out_sel !== 3'd1) begin n_err++; $display("FAIL pre_areset_sel: got %0d want 1", out_sel); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL areset_data: got %h want 00", out_data); end
    n_cmp++; if (out_sel !== 3'd0) begin n_err++; $display("FAIL areset_sel: got %0d want 0", out_sel); end
    step(); step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_rel_valid: got %b want 0", out_valid); end
    for (int j = 0; j < 4; j++) begin
      step();
      n_cmp++; if (out_sel !== 3'(j)) begin n_err++; $display("FAIL areset_scan_sel[%0d]: got %0d want %0d", j, out_sel, j); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL areset_scan_valid[%0d]: got %b want 1", j, out_valid); end
    end
  endtask
  task automatic test_wide();
    sel32 = 5'd31;
    step(); step();
    n_cmp++; if (out_data32 !== 8'h00) begin n_err++; $display("FAIL wide_latency_data: got %h want 00", out_data32); end
    step();
    n_cmp++; if (out_data32 !== 8'hA5) begin n_err++; $display("FAIL wide_data_a5: got %h want a5", out_data32); end
    n_cmp++; if (out_sel32 !== 5'd31) begin n_err++; $display("FAIL wide_sel: got %0d want 31", out_sel32); end
    n_cmp++; if (out_valid32 !== 1'b1) begin n_err++; $display("FAIL wide_valid: got %b want 1", out_valid32); end
`ifdef SCAN_MUX_PARITY_EN
    n_cmp++; if (out_par32 !== 1'b0) begin n_err++; $display("FAIL wide_par_a5: got %b want 0", out_par32); end
`endif
    in_data32[31*8 +: 8] = 8'hA4;
    step(); step(); step();
    n_cmp++; if (out_data32 !== 8'hA4) begin n_err++; $display("FAIL wide_data_a4: got %h want a4", out_data32); end
`ifdef SCAN_MUX_PARITY_EN
    n_cmp++; if (out_par32 !== 1'b1) begin n_err++; $display("FAIL wide_par_a4: got %b want 1", out_par32); end
`endif
    sel32 = 5'd4;
    step(); step(); step();
    n_cmp++; if (out_data32 !== 8'h04) begin n_err++; $display("FAIL wide_data_ch4: got %h want 04", out_data32); end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_manual();
    test_scan_dwell0();
    test_scan_dwell2();
    test_async_reset();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
